instruction_fetch_sequencer: RTL and testbench

Program-counter and fetch controller for the 28-bit instruction ROM. Drives the ROM address, registers the returned instruction into a one-deep fetch register for the execute stage, and resolves `NOP` delays and `JMP` locally. Accepts taken-branch redirects (e.g. `BLE`) and stalls from the execute stage. Sits between the ROM and the CPU decode/execute logic.

---
 rtl/instruction_fetch_sequencer_pkg.sv | 40 ++++
 rtl/instruction_fetch_sequencer.sv | 119 +++++++++++
 tb/tb_instruction_fetch_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch path.
// Holds the opcode codes and instruction field positions used by the fetch
// sequencer and the execute stage, plus small field-extraction helpers.
package instruction_fetch_sequencer_pkg;

  // Instruction word layout (28-bit word)
  localparam int INSN_BITS = 28;
  localparam int OPC_HI    = 27;
  localparam int OPC_LO    = 24;
  localparam int JMP_HI    = 23;
  localparam int JMP_LO    = 16;
  localparam int CNT_HI    = 23;
  localparam int CNT_LO    = 0;
  localparam int OPC_W     = OPC_HI - OPC_LO + 1;
  localparam int JMP_W     = JMP_HI - JMP_LO + 1;
  localparam int CNT_W     = CNT_HI - CNT_LO + 1;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_STO = 4'h3,
    OP_LD  = 4'h4,
    OP_BLE = 4'h5,
    OP_JMP = 4'h6
  } opcode_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSN_BITS-1:0] insn);
    return insn[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [JMP_W-1:0] jmp_target_of(input logic [INSN_BITS-1:0] insn);
    return insn[JMP_HI:JMP_LO];
  endfunction

  function automatic logic [CNT_W-1:0] nop_count_of(input logic [INSN_BITS-1:0] insn);
    return insn[CNT_HI:CNT_LO];
  endfunction

endpackage

// File: rtl/instruction_fetch_sequencer.sv
// Program counter and fetch controller for the instruction ROM.
// Drives the ROM address from the PC, registers the returned word into a
// one-deep fetch register, and resolves NOP delays and JMP locally so they
// never reach execute. Taken-branch redirects and stalls come from execute.
//
// Ports:
//   Clock          system clock, rising edge
//   Reset          synchronous active-high reset
//   iStall         execute cannot accept; freeze all fetch state
//   iBranchTaken   redirect to iBranchTarget (wins over iStall)
//   iBranchTarget  redirect address
//   oAddress       ROM address (the PC register)
//   iInstruction   combinational ROM data for oAddress
//   oInstruction   registered fetched instruction
//   oValid         oInstruction is to be executed
//   oDelayBusy     a NOP delay is counting
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              INSN_W   = 28,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iStall,
  input  logic              iBranchTaken,
  input  logic [ADDR_W-1:0] iBranchTarget,
  output logic [ADDR_W-1:0] oAddress,
  input  logic [INSN_W-1:0] iInstruction,
  output logic [INSN_W-1:0] oInstruction,
  output logic              oValid,
  output logic              oDelayBusy
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DELAY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSN_W-1:0]   insn_q, insn_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [OPC_W-1:0]    opcode;
  logic [JMP_W-1:0]    jmp_tgt;
  logic [CNT_W-1:0]    nop_cnt;

  assign opcode  = iInstruction[OPC_HI:OPC_LO];
  assign jmp_tgt = iInstruction[JMP_HI:JMP_LO];
  assign nop_cnt = iInstruction[CNT_HI:CNT_LO];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      insn_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    insn_d  = insn_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (iBranchTaken) begin
      // Redirect squashes whatever was fetched this cycle and any delay.
      pc_d    = iBranchTarget;
      valid_d = 1'b0;
      cnt_d   = '0;
      state_d = S_FETCH;
    end else if (!iStall) begin
      unique case (state_q)
        S_FETCH: begin
          if (opcode == OP_JMP) begin
            pc_d    = ADDR_W'(jmp_tgt);
            valid_d = 1'b0;
          end else if (opcode == OP_NOP) begin
            valid_d = 1'b0;
            pc_d    = pc_q + ADDR_W'(1);
            if (nop_cnt != '0) begin
              cnt_d   = nop_cnt;
              state_d = S_DELAY;
            end
          end else begin
            insn_d  = iInstruction;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
          end
        end
        S_DELAY: begin
          // PC already points past the NOP; just burn N cycles.
          valid_d = 1'b0;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign oAddress     = pc_q;
  assign oInstruction = insn_q;
  assign oValid       = valid_q;
  assign oDelayBusy   = (state_q == S_DELAY);

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Bench for instruction_fetch_sequencer: directed vector table over a fixed
// program, hand-written reset corner cases, and a randomized run against a
// behavioural model. A second instance checks PC wrap from RESET_PC=FFFF.
module tb_instruction_fetch_sequencer;
  import instruction_fetch_sequencer_pkg::*;

  logic        Clock = 1'b0;
  logic        rst, stall, br;
  logic [15:0] tgt;
  logic [15:0] addr;
  logic [27:0] insn_in, insn_out;
  logic        valid, busy;

  logic        rst2, stall2, br2;
  logic [15:0] tgt2, addr2;
  logic [27:0] insn_in2, insn_out2;
  logic        valid2, busy2;

  logic [27:0] rom [0:65535];

  assign insn_in  = rom[addr];
  assign insn_in2 = rom[addr2];

  always #5 Clock = ~Clock;

  instruction_fetch_sequencer #(.ADDR_W(16), .INSN_W(28), .RESET_PC(16'd0)) dut (
    .Clock(Clock), .Reset(rst), .iStall(stall), .iBranchTaken(br),
    .iBranchTarget(tgt), .oAddress(addr), .iInstruction(insn_in),
    .oInstruction(insn_out), .oValid(valid), .oDelayBusy(busy));

  instruction_fetch_sequencer #(.ADDR_W(16), .INSN_W(28), .RESET_PC(16'hFFFF)) dut_wrap (
    .Clock(Clock), .Reset(rst2), .iStall(stall2), .iBranchTaken(br2),
    .iBranchTarget(tgt2), .oAddress(addr2), .iInstruction(insn_in2),
    .oInstruction(insn_out2), .oValid(valid2), .oDelayBusy(busy2));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic b, input logic [15:0] t);
    stall = s; br = b; tgt = t;
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [27:0] w_nop(input int n);
    logic [27:0] w;
    w = {OP_NOP, 24'(n)};
    return w;
  endfunction

  function automatic logic [27:0] w_jmp(input int t);
    logic [27:0] w;
    w = {OP_JMP, 8'(t), 16'h0};
    return w;
  endfunction

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] e_addr;
    logic        e_valid;
    logic        e_busy;
    int          e_iaddr;   // ROM address of the expected oInstruction, -1 = don't care
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic b, input int t, input int a,
                              input logic v, input logic bz, input int ia);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = 16'(t); r.e_addr = 16'(a);
    r.e_valid = v; r.e_busy = bz; r.e_iaddr = ia;
    return r;
  endfunction

  // Behavioural model state
  int          m_pc, m_delay;
  logic        m_valid;
  logic [27:0] m_insn;

  task automatic model_step(input logic s, input logic b, input int t);
    logic [27:0] w;
    w = rom[m_pc];
    if (b) begin
      m_pc = t; m_valid = 1'b0; m_delay = 0;
    end else if (s) begin
      // frozen
    end else if (m_delay > 0) begin
      m_valid = 1'b0; m_delay = m_delay - 1;
    end else if (w[27:24] == OP_JMP) begin
      m_pc = int'(w[23:16]); m_valid = 1'b0;
    end else if (w[27:24] == OP_NOP) begin
      m_valid = 1'b0; m_pc = (m_pc + 1) % 65536; m_delay = int'(w[23:0]);
    end else begin
      m_insn = w; m_valid = 1'b1; m_pc = (m_pc + 1) % 65536;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0;
    rst2 = 1'b1; stall2 = 1'b0; br2 = 1'b0; tgt2 = '0;

    // Default fill: ADD words tagged with their own address.
    for (int i = 0; i < 65536; i++) rom[i] = {OP_ADD, 8'h00, 16'(i)};
    rom[0]    = w_nop(3);
    rom[1]    = {OP_ADD, 24'h000011};
    rom[2]    = w_nop(0);
    rom[3]    = {OP_STO, 24'h000033};
    rom[4]    = w_jmp(14);
    rom[14]   = w_jmp(2);
    rom[5]    = {OP_ADD, 24'h000055};
    rom[20]   = w_nop(100);
    rom[16'h30] = {OP_SUB, 24'h000030};
    rom[16'hFFFF] = {OP_LD, 24'h00FFFF};

    @(posedge Clock); #1;
    @(posedge Clock); #1;
    chk("rst_addr",  addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_insn",  insn_out, 0);
    chk("rst_wrap_addr", addr2, 16'hFFFF);

    rst = 1'b0; rst2 = 1'b0;
    step(0, 0, 0);
    chk("wrap_addr",  addr2, 16'h0000);
    chk("wrap_valid", valid2, 1);
    chk("wrap_insn",  insn_out2, rom[16'hFFFF]);
    chk("nop3_addr",  addr, 1);
    chk("nop3_busy",  busy, 1);
    chk("nop3_valid", valid, 0);

    vecs.push_back(mk(0,0,0,     1, 0,1,-1));
    vecs.push_back(mk(0,0,0,     1, 0,1,-1));
    vecs.push_back(mk(0,0,0,     1, 0,0,-1));
    vecs.push_back(mk(0,0,0,     2, 1,0, 1));
    vecs.push_back(mk(0,0,0,     3, 0,0,-1));  // NOP 0: one bubble
    vecs.push_back(mk(0,0,0,     4, 1,0, 3));
    vecs.push_back(mk(0,0,0,    14, 0,0,-1));  // JMP 14
    vecs.push_back(mk(0,0,0,     2, 0,0,-1));  // JMP 2 at 14
    vecs.push_back(mk(0,0,0,     3, 0,0,-1));
    vecs.push_back(mk(0,0,0,     4, 1,0, 3));
    vecs.push_back(mk(1,0,0,     4, 1,0, 3));  // 3-cycle stall
    vecs.push_back(mk(1,0,0,     4, 1,0, 3));
    vecs.push_back(mk(1,0,0,     4, 1,0, 3));
    vecs.push_back(mk(0,0,0,    14, 0,0,-1));
    vecs.push_back(mk(0,1,20,   20, 0,0,-1));  // branch beats JMP
    vecs.push_back(mk(0,0,0,    21, 0,1,-1));  // NOP 100
    vecs.push_back(mk(0,0,0,    21, 0,1,-1));
    vecs.push_back(mk(1,0,0,    21, 0,1,-1));  // stall holds DELAY
    vecs.push_back(mk(0,1,5,     5, 0,0,-1));  // branch aborts DELAY
    vecs.push_back(mk(0,0,0,     6, 1,0, 5));
    vecs.push_back(mk(1,1,16'h30, 16'h30, 0,0,-1)); // branch during stall
    vecs.push_back(mk(0,0,0, 16'h31, 1,0, 16'h30));

    foreach (vecs[i]) begin
      step(vecs[i].stall, vecs[i].br, vecs[i].tgt);
      chk($sformatf("vec%0d_addr", i),  addr,  vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), valid, vecs[i].e_valid);
      chk($sformatf("vec%0d_busy", i),  busy,  vecs[i].e_busy);
      if (vecs[i].e_iaddr >= 0)
        chk($sformatf("vec%0d_insn", i), insn_out, rom[vecs[i].e_iaddr]);
    end

    // Reset mid-DELAY: must leave no residual delay.
    step(0, 1, 20);
    step(0, 0, 0);
    chk("mid_delay_busy_pre", busy, 1);
    rst = 1'b1;
    step(0, 0, 0);
    chk("mid_delay_rst_addr",  addr, 0);
    chk("mid_delay_rst_busy",  busy, 0);
    chk("mid_delay_rst_valid", valid, 0);
    chk("mid_delay_rst_insn",  insn_out, 0);
    rst = 1'b0;
    step(0, 0, 0);
    chk("post_rst_nop_busy", busy, 1);
    chk("post_rst_nop_addr", addr, 1);

    // Reset mid-stall.
    step(0, 1, 16'h40);
    step(0, 0, 0);
    rst = 1'b1;
    step(1, 0, 0);
    chk("mid_stall_rst_addr",  addr, 0);
    chk("mid_stall_rst_valid", valid, 0);
    chk("mid_stall_rst_insn",  insn_out, 0);

    // Randomized program in 0..63 with random stalls and branches.
    for (int i = 0; i < 64; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 2)      rom[i] = w_nop($urandom_range(0, 4));
      else if (k < 3) rom[i] = w_jmp($urandom_range(0, 63));
      else            rom[i] = {4'($urandom_range(1, 5)), 24'($urandom)};
    end
    step(0, 0, 0);
    rst = 1'b0;
    m_pc = 0; m_delay = 0; m_valid = 1'b0; m_insn = '0;
    for (int c = 0; c < 1500; c++) begin
      logic s, b;
      int   t;
      s = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 19) == 0);
      t = $urandom_range(0, 63);
      model_step(s, b, t);
      step(s, b, 16'(t));
      chk($sformatf("rnd%0d_addr", c),  addr,  16'(m_pc));
      chk($sformatf("rnd%0d_valid", c), valid, m_valid);
      chk($sformatf("rnd%0d_busy", c),  busy,  (m_delay > 0));
      if (m_valid) chk($sformatf("rnd%0d_insn", c), insn_out, m_insn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
